// File: rtl/accum_status_pkg.sv
// Shared defaults and FSM state encoding for the accumulation status block.
package accum_status_pkg;

    localparam int N_CH_DEF  = 12;
    localparam int OVR_W_DEF = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

endpackage

// File: rtl/accum_status_sticky_flag.sv
// Sticky event bit: set by a pulse, cleared when a snapshot consumes it.
module sticky_flag (
    input  logic clk,
    input  logic rstn,
    input  logic set,
    input  logic clear,
    output logic q
);

    logic q_reg;

    // Clear wins over a coincident set: that set is already folded into the snapshot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_reg <= 1'b0;
        end else if (clear) begin
            q_reg <= 1'b0;
        end else if (set) begin
            q_reg <= 1'b1;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/accum_status.sv
// Accumulation status/interrupt collector: snapshots channel dumps and TICs on accum_enable.
// Optional overrun counter is enabled by defining ACCUM_OVERRUN_CNT_EN.
module accum_status
    import accum_status_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int OVR_W = OVR_W_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             accum_enable,
    input  logic             tic_enable,
    input  logic [N_CH-1:0]  dump,
    input  logic             status_read,
    output logic [N_CH-1:0]  new_data,
    output logic             tic_flag,
    output logic             irq,
    output logic [OVR_W-1:0] overrun_count
);

    state_t          state_reg;
    logic            irq_reg;
    logic [N_CH-1:0] new_data_reg;
    logic            tic_flag_reg;

    logic [N_CH:0]   flag_set;
    logic [N_CH:0]   flag_q;
    logic [N_CH-1:0] pending;
    logic            tic_pending;
    logic [N_CH-1:0] snap_data;
    logic            snap_tic;
    logic            overrun_event;

    // Bits 0..N_CH-1 track channel dumps, bit N_CH tracks the TIC.
    assign flag_set = {tic_enable, dump};

    generate
        for (genvar gi = 0; gi <= N_CH; gi++) begin : g_flag
            sticky_flag u_flag (
                .clk   (clk),
                .rstn  (rstn),
                .set   (flag_set[gi]),
                .clear (accum_enable),
                .q     (flag_q[gi])
            );
        end
    endgenerate

    assign pending     = flag_q[N_CH-1:0];
    assign tic_pending = flag_q[N_CH];

    // Pulses coincident with accum_enable belong to this snapshot.
    assign snap_data = pending | dump;
    assign snap_tic  = tic_pending | tic_enable;

    assign overrun_event = (state_reg == ST_PEND) && accum_enable && !status_read;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= ST_IDLE;
            irq_reg      <= 1'b0;
            new_data_reg <= '0;
            tic_flag_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accum_enable) begin
                        new_data_reg <= snap_data;
                        tic_flag_reg <= snap_tic;
                        state_reg    <= ST_PEND;
                        irq_reg      <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (accum_enable && status_read) begin
                        new_data_reg <= snap_data;
                        tic_flag_reg <= snap_tic;
                        irq_reg      <= 1'b1;
                    end else if (accum_enable) begin
                        // CPU missed the previous snapshot: keep its bits and add the new ones.
                        new_data_reg <= new_data_reg | snap_data;
                        tic_flag_reg <= tic_flag_reg | snap_tic;
                        irq_reg      <= 1'b1;
                    end else if (status_read) begin
                        state_reg <= ST_IDLE;
                        irq_reg   <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    irq_reg   <= 1'b0;
                end
            endcase
        end
    end

`ifdef ACCUM_OVERRUN_CNT_EN
    logic [OVR_W-1:0] overrun_count_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overrun_count_reg <= '0;
        end else if (overrun_event && (overrun_count_reg != {OVR_W{1'b1}})) begin
            overrun_count_reg <= overrun_count_reg + 1'b1;
        end
    end

    assign overrun_count = overrun_count_reg;
`else
    logic unused_overrun;
    assign unused_overrun = overrun_event;
    assign overrun_count  = '0;
`endif

    assign new_data = new_data_reg;
    assign tic_flag = tic_flag_reg;
    assign irq      = irq_reg;

endmodule

// File: doc/accum_status.md
ACCUM_STATUS -- requirements
Module: accum_status

Interface
REQ-001 SHALL have parameter N_CH, default 12, number of tracking channels reporting dumps.
REQ-002 SHALL have parameter OVR_W, default 8, overrun counter width.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port accum_enable  input  1  one-cycle accumulation interrupt pulse from the time base.
REQ-006 SHALL have port tic_enable  input  1  one-cycle TIC pulse from the time base.
REQ-007 SHALL have port dump  input  N_CH  per-channel one-cycle accumulator dump pulses.
REQ-008 SHALL have port status_read  input  1  one-cycle CPU acknowledge that the status word was read.
REQ-009 SHALL have port new_data  output  N_CH  snapshot of channels that dumped since the previous snapshot.
REQ-010 SHALL have port tic_flag  output  1  snapshot: a TIC occurred since the previous snapshot.
REQ-011 SHALL have port irq  output  1  level interrupt to CPU.
REQ-012 SHALL have port overrun_count  output  OVR_W  number of snapshots taken while irq was still set.

Function
REQ-013 SHALL hold internal sticky pending[N_CH] and tic_pending; a dump[i] or tic_enable pulse sets the corresponding bit.
REQ-014 SHALL implement FSM IDLE (irq=0) and PEND (irq=1); irq is a registered decode of state.
REQ-015 SHALL, on accum_enable in IDLE, load new_data <= pending | dump, tic_flag <= tic_pending | tic_enable, clear pending and tic_pending, go to PEND; irq=1 next cycle (latency 1).
REQ-016 SHALL treat a dump or tic_enable coincident with accum_enable as belonging to the current snapshot, not the next.
REQ-017 SHALL, on status_read in PEND without accum_enable, go to IDLE; new_data and tic_flag keep their values.
REQ-018 SHALL, on accum_enable in PEND (overrun), OR-merge: new_data <= new_data | pending | dump, tic_flag likewise, clear pending, stay PEND, increment overrun_count.
REQ-019 SHALL, on accum_enable and status_read in the same PEND cycle, load a fresh snapshot as in REQ-015 (no merge, no overrun count) and stay PEND.
REQ-020 SHALL ignore status_read in IDLE.
REQ-021 SHALL saturate overrun_count at 2^OVR_W-1; no wrap.

Reset
REQ-022 SHALL, while rstn=0, force state IDLE, irq=0, new_data=0, tic_flag=0, pending=0, tic_pending=0, overrun_count=0, asynchronously.
REQ-023 SHALL discard all pending dumps when reset asserts mid-operation; first post-reset accum_enable reports only dumps after release.

Configuration
REQ-024 SHALL use macro ACCUM_OVERRUN_CNT_EN: defined -> overrun counter per REQ-018/021; undefined -> overrun_count tied to 0, no counter flops, merge behaviour unchanged.

Structure
REQ-025 SHALL take N_CH default, OVR_W default and FSM state encoding from a shared package accum_status_pkg.
REQ-026 SHALL contain one sub-module, sticky_flag (set/snapshot-clear bit, async reset), instantiated N_CH+1 times for pending and tic_pending.

Verification
REQ-027 SHALL test: dump[3] at cycle 10, accum_enable at 20 -> irq=1 at 21, new_data=0x008, tic_flag=0.
REQ-028 SHALL test: dump[0] and accum_enable same cycle, tic_enable 5 cycles earlier -> new_data=0x001, tic_flag=1; next snapshot new_data=0.
REQ-029 SHALL test: snapshot dump[1]; no status_read; dump[2] then accum_enable -> new_data=0x006, irq=1, overrun_count=1.
REQ-030 SHALL test: 300 consecutive unread accum_enable pulses (macro defined) -> overrun_count=255; macro undefined -> 0.
REQ-031 SHALL test: status_read and accum_enable same cycle in PEND with dump[5] pending -> new_data=0x020, irq stays 1, overrun_count unchanged.
REQ-032 SHALL test: dump[7] pending, rstn low 1 cycle mid-run -> all outputs 0 immediately; next accum_enable yields new_data=0.
